// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch aligner: FSM state encodings
// and the RISC-V low-bit pattern that marks a 32-bit instruction.
package fetch_pkg;

    typedef enum logic {
        S_LO = 1'b0,
        S_HI = 1'b1
    } fetchState_e;

    localparam logic [1:0] RVC_LEN32 = 2'b11;

endpackage

// File: rtl/fetch_aligner.sv
// Instruction fetch aligner with a one-word buffer in front of a read-only I-cache.
// Define RVC_EN to enable 16-bit compressed instructions and word-straddling fetches.
module fetch_aligner
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        proc_reset_n,
    input  logic [31:0] core_pc,
    input  logic        core_req,
    input  logic        core_flush,
    output logic [31:0] core_instr,
    output logic        core_instr_valid,
    output logic        core_instr_c,
    output logic        core_stall,
    output logic        ic_read,
    output logic [29:0] ic_addr,
    input  logic [31:0] ic_rdata,
    input  logic        ic_stall
);

    logic        r_bufValid;
    logic [29:0] r_bufAddr;
    logic [31:0] r_bufData;

    logic [29:0] w_fetchAddr;
    logic        w_active;
    logic        w_bufHit;
    logic        w_wordReady;
    logic [31:0] w_word;
    logic        w_unusedPc;

    assign w_unusedPc = ^core_pc[1:0];

`ifdef RVC_EN
    fetchState_e r_state;
    fetchState_e w_nextState;
    logic [15:0] r_hiSave;
    logic [15:0] w_half;
    logic        w_saveHi;

    assign w_fetchAddr = (r_state == S_HI) ? core_pc[31:2] + 30'd1 : core_pc[31:2];
`else
    assign w_fetchAddr = core_pc[31:2];
`endif

    // Reset is folded in so the cache request drops the instant reset asserts.
    assign w_active    = proc_reset_n & core_req & ~core_flush;
    assign w_bufHit    = r_bufValid && (r_bufAddr == w_fetchAddr);
    assign w_wordReady = w_active & (w_bufHit | ~ic_stall);
    assign w_word      = w_bufHit ? r_bufData : ic_rdata;

    assign ic_read    = w_active & ~w_bufHit;
    assign ic_addr    = w_fetchAddr;
    assign core_stall = core_req & ~core_instr_valid;

    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n) begin
            r_bufValid <= 1'b0;
            r_bufAddr  <= '0;
            r_bufData  <= '0;
        end else if (ic_read && !ic_stall) begin
            r_bufValid <= 1'b1;
            r_bufAddr  <= ic_addr;
            r_bufData  <= ic_rdata;
        end
    end

`ifdef RVC_EN
    assign w_half = core_pc[1] ? w_word[31:16] : w_word[15:0];

    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n) begin
            r_state  <= S_LO;
            r_hiSave <= '0;
        end else begin
            r_state <= w_nextState;
            if (w_saveHi) begin
                r_hiSave <= w_half;
            end
        end
    end

    // A straddling instruction parks its low half in r_hiSave while S_HI fetches the next word.
    always_comb begin
        w_nextState      = r_state;
        w_saveHi         = 1'b0;
        core_instr       = '0;
        core_instr_valid = 1'b0;
        core_instr_c     = 1'b0;
        if (!core_req || core_flush) begin
            w_nextState = S_LO;
        end else if (w_wordReady) begin
            case (r_state)
                S_LO: begin
                    if (w_half[1:0] != RVC_LEN32) begin
                        core_instr       = {16'b0, w_half};
                        core_instr_valid = 1'b1;
                        core_instr_c     = 1'b1;
                    end else if (!core_pc[1]) begin
                        core_instr       = w_word;
                        core_instr_valid = 1'b1;
                    end else begin
                        w_saveHi    = 1'b1;
                        w_nextState = S_HI;
                    end
                end
                S_HI: begin
                    core_instr       = {w_word[15:0], r_hiSave};
                    core_instr_valid = 1'b1;
                    w_nextState      = S_LO;
                end
                default: w_nextState = S_LO;
            endcase
        end
    end
`else
    assign core_instr_c = 1'b0;

    always_comb begin
        core_instr       = '0;
        core_instr_valid = 1'b0;
        if (w_wordReady) begin
            core_instr       = w_word;
            core_instr_valid = 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_aligner.sv
// Self-checking bench for fetch_aligner: constant vector table, hand-written corner
// sequences and a random run checked against a word-queue reference model.
module tb_fetch_aligner;

`ifdef RVC_EN
    localparam bit RVC = 1'b1;
`else
    localparam bit RVC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        proc_reset_n;
    logic [31:0] core_pc;
    logic        core_req;
    logic        core_flush;
    logic [31:0] core_instr;
    logic        core_instr_valid;
    logic        core_instr_c;
    logic        core_stall;
    logic        ic_read;
    logic [29:0] ic_addr;
    logic [31:0] ic_rdata;
    logic        ic_stall;

    int checks = 0;
    int errors = 0;

    logic [31:0] seed;
    logic [31:0] memOverride [logic [29:0]];

    bit          mBufValid;
    logic [29:0] mBufAddr;
    logic [29:0] needQ [$];
    bit          expValid;
    bit          expRead;
    bit          expC;
    logic [29:0] expAddr;
    logic [31:0] expInstr;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] expInstr;
        bit          expC;
        int          expLat;
        logic [29:0] expLastAddr;
    } vec_t;

    fetch_aligner dut (
        .clk              (clk),
        .proc_reset_n     (proc_reset_n),
        .core_pc          (core_pc),
        .core_req         (core_req),
        .core_flush       (core_flush),
        .core_instr       (core_instr),
        .core_instr_valid (core_instr_valid),
        .core_instr_c     (core_instr_c),
        .core_stall       (core_stall),
        .ic_read          (ic_read),
        .ic_addr          (ic_addr),
        .ic_rdata         (ic_rdata),
        .ic_stall         (ic_stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] memWord(input logic [29:0] a);
        logic [31:0] x;
        if (memOverride.exists(a)) return memOverride[a];
        x = ({2'b0, a} * 32'h9E3779B1) ^ seed;
        x = x ^ (x >> 15);
        x = x * 32'h85EBCA6B;
        x = x ^ (x >> 13);
        return x;
    endfunction

    function automatic logic [15:0] halfAt(input logic [31:0] byteAddr);
        logic [31:0] w;
        w = memWord(byteAddr[31:2]);
        return byteAddr[1] ? w[31:16] : w[15:0];
    endfunction

    // Ideal decode straight from memory contents, independent of how words are fetched.
    task automatic refInstr(input logic [31:0] pc, output logic [31:0] instr, output bit c);
        logic [15:0] h;
        if (RVC) begin
            h = halfAt(pc);
            if (h[1:0] != 2'b11) begin
                instr = {16'h0, h};
                c     = 1'b1;
            end else begin
                instr = {halfAt(pc + 32'd2), h};
                c     = 1'b0;
            end
        end else begin
            instr = memWord(pc[31:2]);
            c     = 1'b0;
        end
    endtask

    // Each instruction needs a list of words; at most one arrives per cycle,
    // from the buffered word for free or from the cache when it is not stalled.
    task automatic modelStep(input logic [31:0] pc, input bit r, input bit f, input bit s);
        logic [29:0] front;
        logic [15:0] h;
        bit          hit;
        expValid = 1'b0;
        expRead  = 1'b0;
        expC     = 1'b0;
        expAddr  = '0;
        expInstr = '0;
        if (!r || f) begin
            needQ.delete();
        end else begin
            if (needQ.size() == 0) begin
                needQ.push_back(pc[31:2]);
                h = halfAt(pc);
                if (RVC && pc[1] && h[1:0] == 2'b11) needQ.push_back(pc[31:2] + 30'd1);
            end
            front   = needQ[0];
            hit     = mBufValid && (mBufAddr == front);
            expRead = !hit;
            expAddr = front;
            if (hit || !s) begin
                if (!hit) begin
                    mBufValid = 1'b1;
                    mBufAddr  = front;
                end
                void'(needQ.pop_front());
                if (needQ.size() == 0) begin
                    expValid = 1'b1;
                    refInstr(pc, expInstr, expC);
                end
            end
        end
    endtask

    task automatic checkOutput(input bit r);
        check("valid", {31'b0, core_instr_valid}, {31'b0, expValid});
        check("ic_read", {31'b0, ic_read}, {31'b0, expRead});
        check("core_stall", {31'b0, core_stall}, {31'b0, r & ~expValid});
        if (expRead) check("ic_addr", {2'b0, ic_addr}, {2'b0, expAddr});
        if (expValid) begin
            check("instr", core_instr, expInstr);
            check("instr_c", {31'b0, core_instr_c}, {31'b0, expC});
        end
    endtask

    // One clock cycle: drive at the falling edge, answer the cache, then compare.
    task automatic applyStimulus(input logic [31:0] pc, input bit r, input bit f, input bit s);
        @(negedge clk);
        core_pc    = pc;
        core_req   = r;
        core_flush = f;
        ic_stall   = s;
        #1;
        ic_rdata = s ? $urandom : memWord(ic_addr);
        #1;
        modelStep(pc, r, f, s);
        checkOutput(r);
    endtask

    task automatic doReset();
        @(negedge clk);
        proc_reset_n = 1'b0;
        core_req     = 1'b1;
        core_flush   = 1'b0;
        ic_stall     = 1'b0;
        #1;
        check("rst valid", {31'b0, core_instr_valid}, 32'd0);
        check("rst ic_read", {31'b0, ic_read}, 32'd0);
        check("rst instr_c", {31'b0, core_instr_c}, 32'd0);
        check("rst core_stall", {31'b0, core_stall}, 32'd1);
        @(negedge clk);
        proc_reset_n = 1'b1;
        core_req     = 1'b0;
        mBufValid    = 1'b0;
        mBufAddr     = '0;
        needQ.delete();
    endtask

    initial begin
        vec_t        vecs [$];
        logic [31:0] pc;
        int          lat;
        bit          got;
        bit          done;

        seed         = $urandom;
        proc_reset_n = 1'b0;
        core_pc      = '0;
        core_req     = 1'b0;
        core_flush   = 1'b0;
        ic_stall     = 1'b0;
        ic_rdata     = '0;
        mBufValid    = 1'b0;
        mBufAddr     = '0;

`ifdef RVC_EN
        vecs.push_back('{32'h0000_0100, 32'h00A0_0093, 32'h0000_0000, 32'h00A0_0093, 1'b0, 1, 30'h40});
        vecs.push_back('{32'h0000_0100, 32'h4505_0001, 32'h0000_0000, 32'h0000_0001, 1'b1, 1, 30'h40});
        vecs.push_back('{32'h0000_0102, 32'h4505_0001, 32'h0000_0000, 32'h0000_4505, 1'b1, 1, 30'h40});
        vecs.push_back('{32'h0000_0106, 32'h0093_1234, 32'h5678_00A0, 32'h00A0_0093, 1'b0, 2, 30'h42});
        vecs.push_back('{32'hFFFF_FFFE, 32'h0513_0000, 32'h0000_0005, 32'h0005_0513, 1'b0, 2, 30'h0});
        vecs.push_back('{32'h0000_0201, 32'h1234_5677, 32'h0000_0000, 32'h1234_5677, 1'b0, 1, 30'h80});
        vecs.push_back('{32'h0000_0202, 32'h8082_4111, 32'h0000_0000, 32'h0000_8082, 1'b1, 1, 30'h80});
`else
        vecs.push_back('{32'h0000_0100, 32'h00A0_0093, 32'h0000_0000, 32'h00A0_0093, 1'b0, 1, 30'h40});
        vecs.push_back('{32'h0000_0102, 32'h4505_0001, 32'h0000_0000, 32'h4505_0001, 1'b0, 1, 30'h40});
        vecs.push_back('{32'h0000_0106, 32'h0093_1234, 32'h5678_00A0, 32'h0093_1234, 1'b0, 1, 30'h41});
        vecs.push_back('{32'hFFFF_FFFE, 32'h0513_0000, 32'h0000_0005, 32'h0513_0000, 1'b0, 1, 30'h3FFFFFFF});
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            doReset();
            memOverride.delete();
            memOverride[vecs[i].pc[31:2]]         = vecs[i].w0;
            memOverride[vecs[i].pc[31:2] + 30'd1] = vecs[i].w1;
            lat = 0;
            got = 1'b0;
            for (int c = 0; c < 8 && !got; c++) begin
                applyStimulus(vecs[i].pc, 1'b1, 1'b0, 1'b0);
                lat++;
                if (core_instr_valid) begin
                    got = 1'b1;
                    check($sformatf("vec%0d instr", i), core_instr, vecs[i].expInstr);
                    check($sformatf("vec%0d instr_c", i), {31'b0, core_instr_c}, {31'b0, vecs[i].expC});
                    check($sformatf("vec%0d latency", i), lat, vecs[i].expLat);
                    check($sformatf("vec%0d last ic_addr", i), {2'b0, ic_addr}, {2'b0, vecs[i].expLastAddr});
                end
            end
            if (!got) check($sformatf("vec%0d timeout", i), {31'b0, core_instr_valid}, 32'd1);
        end

        // Second halfword of an already-fetched word comes from the buffer.
        doReset();
        memOverride.delete();
        memOverride[30'h40] = 32'h4505_0001;
        applyStimulus(32'h100, 1'b1, 1'b0, 1'b0);
        applyStimulus(32'h102, 1'b1, 1'b0, 1'b1);
        check("buf ic_read", {31'b0, ic_read}, 32'd0);
        check("buf valid", {31'b0, core_instr_valid}, 32'd1);
`ifdef RVC_EN
        check("buf instr", core_instr, 32'h0000_4505);
        check("buf instr_c", {31'b0, core_instr_c}, 32'd1);
`else
        check("buf instr", core_instr, 32'h4505_0001);
`endif

        // Long cache stall: an abandoned stalled access must not disturb the buffer.
        memOverride[30'hC0] = 32'h00A0_0093;
        for (int c = 0; c < 5; c++) begin
            applyStimulus(32'h300, 1'b1, 1'b0, 1'b1);
            check("stall core_stall", {31'b0, core_stall}, 32'd1);
        end
        applyStimulus(32'h300, 1'b0, 1'b0, 1'b0);
        applyStimulus(32'h100, 1'b1, 1'b0, 1'b1);
        check("stall buf kept", {31'b0, ic_read}, 32'd0);
        for (int c = 0; c < 5; c++) begin
            applyStimulus(32'h300, 1'b1, 1'b0, 1'b1);
            check("stall5 core_stall", {31'b0, core_stall}, 32'd1);
        end
        applyStimulus(32'h300, 1'b1, 1'b0, 1'b0);
        check("stall5 valid 6th", {31'b0, core_instr_valid}, 32'd1);
        check("stall5 instr", core_instr, 32'h00A0_0093);

        // Flush aborts a fetch without touching the buffer.
        doReset();
        memOverride[30'h41] = 32'h0093_1234;
        memOverride[30'h42] = 32'h5678_00A0;
        applyStimulus(32'h106, 1'b1, 1'b0, 1'b0);
        applyStimulus(32'h106, 1'b1, 1'b1, 1'b0);
        check("flush valid", {31'b0, core_instr_valid}, 32'd0);
        check("flush ic_read", {31'b0, ic_read}, 32'd0);
        applyStimulus(32'h106, 1'b1, 1'b0, 1'b1);
`ifdef RVC_EN
        check("flush back to lo addr", {2'b0, ic_addr}, 32'h41);
        check("flush lo buffered", {31'b0, ic_read}, 32'd0);
        applyStimulus(32'h106, 1'b1, 1'b0, 1'b0);
        check("flush hi addr", {2'b0, ic_addr}, 32'h42);
        check("flush straddle instr", core_instr, 32'h00A0_0093);
`else
        check("flush rebuffered valid", {31'b0, core_instr_valid}, 32'd1);
`endif

        // Reset in the middle of a stalled fetch.
        applyStimulus(32'h100, 1'b1, 1'b0, 1'b0);
        applyStimulus(32'h500, 1'b1, 1'b0, 1'b1);
        proc_reset_n = 1'b0;
        #1;
        check("midrst ic_read", {31'b0, ic_read}, 32'd0);
        check("midrst valid", {31'b0, core_instr_valid}, 32'd0);
        check("midrst core_stall", {31'b0, core_stall}, 32'd1);
        @(negedge clk);
        proc_reset_n = 1'b1;
        core_req     = 1'b0;
        mBufValid    = 1'b0;
        needQ.delete();
        applyStimulus(32'h100, 1'b1, 1'b0, 1'b1);
        check("midrst buf cleared", {31'b0, ic_read}, 32'd1);
        applyStimulus(32'h100, 1'b1, 1'b0, 1'b0);

        // Random fetch stream over a small window plus the top-of-memory wrap.
        doReset();
        memOverride.delete();
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 7) == 0)
                pc = 32'hFFFF_FFF8 + 32'($urandom_range(0, 3)) * 32'd2 + 32'($urandom_range(0, 1));
            else
                pc = 32'h0000_1000 + 32'($urandom_range(0, 31)) * 32'd2 + 32'($urandom_range(0, 1));
            done = 1'b0;
            for (int c = 0; c < 40 && !done; c++) begin
                applyStimulus(pc, $urandom_range(0, 15) != 0, $urandom_range(0, 15) == 0,
                              $urandom_range(0, 2) == 0);
                if (expValid) done = 1'b1;
            end
            if (!done) check("random timeout", {31'b0, core_instr_valid}, 32'd1);
            if ($urandom_range(0, 5) == 0) applyStimulus(pc, 1'b0, 1'b0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
